// File: rtl/riscv_pkg.sv
// Shared types and constants for the unified memory arbiter.
package riscv_pkg;

    // Arbiter transaction phases.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    // Which requester owns the transaction in flight.
    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_IF   = 2'd1,
        GRANT_DATA = 2'd2
    } arb_grant_e;

    // Instruction fetches always read a whole word.
    localparam logic [3:0] MEM_BE_FULL = 4'hF;

    // Bits needed to hold a counter that runs from 0 up to max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arb_grant_select.sv
// Winner selection between fetch and data requesters, with the
// starvation counter that bounds how long a pending fetch can wait.
module arb_grant_select
    import riscv_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       idle,
    input  logic       if_valid,
    input  logic       d_valid,
    output arb_grant_e grant
);

    localparam int SCW = cnt_width(STARVE_LIMIT);
    localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

    logic [SCW-1:0] starve_cnt;
    logic           starve_hit;

    assign starve_hit = (starve_cnt == STARVE_MAX);

    // Pick the winner: data has priority unless fetch has been starved long enough.
    always_comb begin
        grant = GRANT_NONE;
        if (!rst && idle) begin
            if (if_valid && d_valid) begin
                grant = starve_hit ? GRANT_IF : GRANT_DATA;
            end else if (if_valid) begin
                grant = GRANT_IF;
            end else if (d_valid) begin
                grant = GRANT_DATA;
            end
        end
    end

    // Count data grants that were taken while a fetch was left waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant == GRANT_IF) begin
            starve_cnt <= '0;
        end else if (grant == GRANT_DATA && if_valid && !starve_hit) begin
            starve_cnt <= starve_cnt + SCW'(1);
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port unified memory arbiter for the multi-cycle core: one
// transaction at a time, fixed read latency, one-cycle response pulse.
module unified_mem_arbiter
    import riscv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            if_req_valid,
    output logic            if_req_ready,
    input  logic [XLEN-1:0] if_req_addr,
    output logic            if_rsp_valid,
    output logic [XLEN-1:0] if_rsp_data,

    input  logic            d_req_valid,
    output logic            d_req_ready,
    input  logic [XLEN-1:0] d_req_addr,
    input  logic            d_req_we,
    input  logic [XLEN-1:0] d_req_wdata,
    input  logic [3:0]      d_req_be,
    output logic            d_rsp_valid,
    output logic [XLEN-1:0] d_rsp_data,

    output logic            mem_en,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int WCW = cnt_width(MEM_LATENCY);
    localparam logic [WCW-1:0] WAIT_LOAD = WCW'(MEM_LATENCY);
    localparam logic [WCW-1:0] WAIT_ONE  = WCW'(1);

    arb_state_e     state;
    arb_grant_e     grant;
    arb_grant_e     grant_q;
    logic [WCW-1:0] wait_cnt;

    arb_grant_select #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant_select (
        .clk      (clk),
        .rst      (rst),
        .idle     (state == ARB_IDLE),
        .if_valid (if_req_valid),
        .d_valid  (d_req_valid),
        .grant    (grant)
    );

    // Only the chosen requester sees ready; the grant is already idle- and reset-qualified.
    always_comb begin
        if_req_ready = (grant == GRANT_IF);
        d_req_ready  = (grant == GRANT_DATA);
    end

    // Transaction FSM; the memory strobe and response pulses are registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ARB_IDLE;
            grant_q      <= GRANT_NONE;
            wait_cnt     <= '0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            d_rsp_valid  <= 1'b0;
            d_rsp_data   <= '0;
        end else begin
            mem_en       <= 1'b0;
            if_rsp_valid <= 1'b0;
            d_rsp_valid  <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant != GRANT_NONE) begin
                        grant_q <= grant;
                        mem_en  <= 1'b1;
                        state   <= ARB_ISSUE;
                        if (grant == GRANT_IF) begin
                            mem_addr  <= if_req_addr;
                            mem_we    <= 1'b0;
                            mem_wdata <= '0;
                            mem_be    <= MEM_BE_FULL;
                        end else begin
                            mem_addr  <= d_req_addr;
                            mem_we    <= d_req_we;
                            mem_wdata <= d_req_wdata;
                            mem_be    <= d_req_be;
                        end
                    end
                end
                ARB_ISSUE: begin
                    wait_cnt <= WAIT_LOAD;
                    state    <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    wait_cnt <= wait_cnt - WAIT_ONE;
                    if (wait_cnt == WAIT_ONE) begin
                        state <= ARB_RESP;
                        if (grant_q == GRANT_IF) begin
                            if_rsp_valid <= 1'b1;
                            if_rsp_data  <= mem_rdata;
                        end else begin
                            d_rsp_valid <= 1'b1;
                            d_rsp_data  <= mem_we ? '0 : mem_rdata;
                        end
                    end
                end
                ARB_RESP: begin
                    state <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios plus a
// randomized run compared against a transaction-level timing model.
module tb_unified_mem_arbiter;

    localparam int LAT_A   = 2;
    localparam int LAT_B   = 1;
    localparam int LIMIT   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_valid = 1'b0;
    logic [31:0] if_req_addr = '0;
    logic        d_req_valid = 1'b0;
    logic [31:0] d_req_addr = '0;
    logic        d_req_we = 1'b0;
    logic [31:0] d_req_wdata = '0;
    logic [3:0]  d_req_be = '0;

    logic        if_req_ready, if_rsp_valid, d_req_ready, d_rsp_valid;
    logic [31:0] if_rsp_data, d_rsp_data;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    logic        l1_if_req_ready, l1_if_rsp_valid, l1_d_req_ready, l1_d_rsp_valid;
    logic [31:0] l1_if_rsp_data, l1_d_rsp_data;
    logic        l1_mem_en, l1_mem_we;
    logic [31:0] l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
    logic [3:0]  l1_mem_be;

    logic        ovr_en = 1'b0;
    logic [31:0] ovr_val = '0;
    logic [31:0] pipe_a [LAT_A];
    logic [31:0] pipe_b [LAT_B];

    int checks = 0;
    int passed = 0;

    unified_mem_arbiter #(.XLEN(32), .MEM_LATENCY(LAT_A), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_we(d_req_we), .d_req_wdata(d_req_wdata), .d_req_be(d_req_be),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    unified_mem_arbiter #(.XLEN(32), .MEM_LATENCY(LAT_B), .STARVE_LIMIT(LIMIT)) dut_l1 (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(l1_if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(l1_if_rsp_valid), .if_rsp_data(l1_if_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(l1_d_req_ready), .d_req_addr(d_req_addr),
        .d_req_we(d_req_we), .d_req_wdata(d_req_wdata), .d_req_be(d_req_be),
        .d_rsp_valid(l1_d_rsp_valid), .d_rsp_data(l1_d_rsp_data),
        .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
        .mem_be(l1_mem_be), .mem_rdata(l1_mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory contents as seen by the core: a fixed instruction at 0x100, a hash elsewhere.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h100) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
    endfunction

    // Memory for the latency-2 instance; cycles without a pending read carry random junk.
    always @(posedge clk) begin
        pipe_a[0] <= mem_en ? mem_val(mem_addr) : $urandom;
        for (int i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
    end

    // Memory for the latency-1 instance.
    always @(posedge clk) begin
        pipe_b[0] <= l1_mem_en ? mem_val(l1_mem_addr) : $urandom;
        for (int i = 1; i < LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
    end

    assign mem_rdata    = ovr_en ? ovr_val : pipe_a[LAT_A-1];
    assign l1_mem_rdata = pipe_b[LAT_B-1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if_req_valid = 1'b0;
        d_req_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_req_valid = 1'b1; if_req_addr = 32'h44;
        d_req_valid = 1'b1;  d_req_addr = 32'h88; d_req_we = 1'b1; d_req_be = 4'h5;
        step();
        step();
        @(negedge clk);
        checks++;
        if ({if_req_ready, d_req_ready} !== 2'b00) $display("[TB] FAIL reset_ready got=%b exp=00", {if_req_ready, d_req_ready});
        else passed++;
        checks++;
        if ({if_rsp_valid, d_rsp_valid, mem_en, mem_we, mem_be, mem_addr, mem_wdata, if_rsp_data, d_rsp_data} !== '0)
            $display("[TB] FAIL reset_outputs got=%h exp=0", {if_rsp_valid, d_rsp_valid, mem_en, mem_we, mem_be, mem_addr, mem_wdata, if_rsp_data, d_rsp_data});
        else passed++;
        checks++;
        if ({l1_if_req_ready, l1_d_req_ready, l1_mem_en, l1_if_rsp_valid, l1_d_rsp_valid} !== '0)
            $display("[TB] FAIL reset_l1_outputs got=%b exp=0", {l1_if_req_ready, l1_d_req_ready, l1_mem_en, l1_if_rsp_valid, l1_d_rsp_valid});
        else passed++;
        step();
        rst = 1'b0; if_req_valid = 1'b0; d_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid, mem_en, mem_we, mem_be, mem_addr, mem_wdata, if_rsp_data, d_rsp_data} !== '0)
            $display("[TB] FAIL post_reset_outputs got=%h exp=0", {if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid, mem_en, mem_we, mem_be, mem_addr, mem_wdata, if_rsp_data, d_rsp_data});
        else passed++;
    endtask

    task automatic test_fetch_read();
        step();
        if_req_valid = 1'b1; if_req_addr = 32'h100; d_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({if_req_ready, d_req_ready} !== 2'b10) $display("[TB] FAIL fetch_ready got=%b exp=10", {if_req_ready, d_req_ready});
        else passed++;
        step();
        if_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b0, 4'hF, 32'h100, 32'h0})
            $display("[TB] FAIL fetch_issue got=%h exp=%h", {mem_en, mem_we, mem_be, mem_addr, mem_wdata}, {1'b1, 1'b0, 4'hF, 32'h100, 32'h0});
        else passed++;
        step();
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b0) $display("[TB] FAIL fetch_en_pulse got=%b exp=0", mem_en);
        else passed++;
        step();
        @(negedge clk);
        checks++;
        if (if_rsp_valid !== 1'b0) $display("[TB] FAIL fetch_rsp_early got=%b exp=0", if_rsp_valid);
        else passed++;
        step();
        @(negedge clk);
        checks++;
        if ({if_rsp_valid, d_rsp_valid, if_rsp_data} !== {2'b10, 32'h0050_0093})
            $display("[TB] FAIL fetch_rsp got=%h exp=%h", {if_rsp_valid, d_rsp_valid, if_rsp_data}, {2'b10, 32'h0050_0093});
        else passed++;
        step();
        @(negedge clk);
        checks++;
        if ({if_rsp_valid, if_rsp_data} !== {1'b0, 32'h0050_0093})
            $display("[TB] FAIL fetch_rsp_hold got=%h exp=%h", {if_rsp_valid, if_rsp_data}, {1'b0, 32'h0050_0093});
        else passed++;
    endtask

    task automatic test_store();
        step();
        d_req_valid = 1'b1; d_req_addr = 32'h2000; d_req_we = 1'b1;
        d_req_wdata = 32'hDEAD_BEEF; d_req_be = 4'h3;
        @(negedge clk);
        checks++;
        if ({if_req_ready, d_req_ready} !== 2'b01) $display("[TB] FAIL store_ready got=%b exp=01", {if_req_ready, d_req_ready});
        else passed++;
        step();
        d_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'h3, 32'h2000, 32'hDEAD_BEEF})
            $display("[TB] FAIL store_issue got=%h exp=%h", {mem_en, mem_we, mem_be, mem_addr, mem_wdata}, {1'b1, 1'b1, 4'h3, 32'h2000, 32'hDEAD_BEEF});
        else passed++;
        step(); step(); step();
        @(negedge clk);
        checks++;
        if ({d_rsp_valid, if_rsp_valid, d_rsp_data} !== {2'b10, 32'h0})
            $display("[TB] FAIL store_ack got=%h exp=%h", {d_rsp_valid, if_rsp_valid, d_rsp_data}, {2'b10, 32'h0});
        else passed++;
        step();
    endtask

    task automatic test_starvation();
        string exp_seq;
        int grants;
        int starve;
        int last_acc;
        do_reset();
        if_req_valid = 1'b1; if_req_addr = 32'h400;
        d_req_valid = 1'b1;  d_req_addr = 32'h800; d_req_we = 1'b0; d_req_be = 4'hF;
        grants = 0; starve = 0; last_acc = -1;
        for (int cyc = 0; cyc < 200 && grants < 10; cyc++) begin
            @(negedge clk);
            if (if_req_ready && d_req_ready) begin
                checks++;
                $display("[TB] FAIL starve_both_ready cycle=%0d got=11 exp=one-hot", cyc);
            end
            if (if_req_ready || d_req_ready) begin
                exp_seq = (starve == LIMIT) ? "I" : "D";
                checks++;
                if ((if_req_ready ? "I" : "D") != exp_seq)
                    $display("[TB] FAIL starve_grant_%0d got=%s exp=%s", grants, if_req_ready ? "I" : "D", exp_seq);
                else passed++;
                starve = (exp_seq == "I") ? 0 : ((starve < LIMIT) ? starve + 1 : LIMIT);
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != LAT_A + 3)
                        $display("[TB] FAIL starve_spacing got=%0d exp=%0d", cyc - last_acc, LAT_A + 3);
                    else passed++;
                end
                last_acc = cyc;
                grants++;
            end
            step();
        end
        checks++;
        if (grants != 10) $display("[TB] FAIL starve_timeout got=%0d grants exp=10", grants);
        else passed++;
        if_req_valid = 1'b0; d_req_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        d_req_valid = 1'b1; d_req_addr = 32'h1234; d_req_we = 1'b0; d_req_be = 4'hF;
        for (int c = 0; c <= 2 * (LAT_A + 3); c++) begin
            @(negedge clk);
            checks++;
            if ({if_req_ready, d_req_ready} !== {1'b0, (c % (LAT_A + 3)) == 0})
                $display("[TB] FAIL b2b_ready cycle=%0d got=%b exp=%b", c, {if_req_ready, d_req_ready}, {1'b0, (c % (LAT_A + 3)) == 0});
            else passed++;
            step();
        end
        d_req_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        d_req_valid = 1'b1; d_req_addr = 32'h3000; d_req_we = 1'b0; d_req_be = 4'hF;
        @(negedge clk);
        checks++;
        if (d_req_ready !== 1'b1) $display("[TB] FAIL abort_accept got=%b exp=1", d_req_ready);
        else passed++;
        step();
        d_req_valid = 1'b0;
        step();
        rst = 1'b1; if_req_valid = 1'b1; if_req_addr = 32'h500;
        @(negedge clk);
        checks++;
        if ({if_req_ready, d_rsp_valid} !== 2'b00) $display("[TB] FAIL abort_in_reset got=%b exp=00", {if_req_ready, d_rsp_valid});
        else passed++;
        step();
        rst = 1'b0; ovr_en = 1'b1; ovr_val = 32'hBAD0_BAD0;
        @(negedge clk);
        checks++;
        if ({if_req_ready, d_rsp_valid, mem_en} !== 3'b100) $display("[TB] FAIL abort_idle got=%b exp=100", {if_req_ready, d_rsp_valid, mem_en});
        else passed++;
        step();
        if_req_valid = 1'b0;
        for (int c = 4; c <= 8; c++) begin
            if (c == 6) ovr_en = 1'b0;
            @(negedge clk);
            checks++;
            if ({if_rsp_valid, d_rsp_valid} !== {c == 7, 1'b0})
                $display("[TB] FAIL abort_rsp cycle=%0d got=%b exp=%b", c, {if_rsp_valid, d_rsp_valid}, {c == 7, 1'b0});
            else passed++;
            if (c == 4) begin
                checks++;
                if ({mem_en, mem_addr} !== {1'b1, 32'h500}) $display("[TB] FAIL abort_next_issue got=%h exp=%h", {mem_en, mem_addr}, {1'b1, 32'h500});
                else passed++;
            end
            if (c == 7) begin
                checks++;
                if (if_rsp_data !== mem_val(32'h500)) $display("[TB] FAIL abort_next_data got=%h exp=%h", if_rsp_data, mem_val(32'h500));
                else passed++;
            end
            step();
        end
        checks++;
        if (d_rsp_data !== 32'h0) $display("[TB] FAIL abort_d_data got=%h exp=0", d_rsp_data);
        else passed++;
    endtask

    task automatic test_latency1();
        do_reset();
        if_req_valid = 1'b1; if_req_addr = 32'h40; d_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (l1_if_req_ready !== 1'b1) $display("[TB] FAIL l1_accept got=%b exp=1", l1_if_req_ready);
        else passed++;
        step();
        if_req_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if ({l1_mem_en, l1_if_rsp_valid} !== {c == 1, c == 3})
                $display("[TB] FAIL l1_timing cycle=%0d got=%b exp=%b", c, {l1_mem_en, l1_if_rsp_valid}, {c == 1, c == 3});
            else passed++;
            if (c == 3) begin
                checks++;
                if (l1_if_rsp_data !== mem_val(32'h40)) $display("[TB] FAIL l1_data got=%h exp=%h", l1_if_rsp_data, mem_val(32'h40));
                else passed++;
            end
            step();
        end
    endtask

    task automatic test_random();
        int next_free, starve, mem_cyc, rsp_cyc;
        bit rsp_if, e_if_rdy, e_d_rdy;
        logic [31:0] exp_if, exp_d, pend_data;
        logic [68:0] e_mem;
        do_reset();
        next_free = 0; starve = 0; mem_cyc = -1; rsp_cyc = -1; rsp_if = 1'b0;
        exp_if = '0; exp_d = '0; pend_data = '0; e_mem = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if_req_valid = ($urandom_range(0, 99) < 55);
            if_req_addr  = ($urandom_range(0, 3) == 0) ? 32'h100 : $urandom;
            d_req_valid  = ($urandom_range(0, 99) < 55);
            d_req_addr   = $urandom;
            d_req_we     = $urandom_range(0, 1) == 1;
            d_req_wdata  = $urandom;
            d_req_be     = 4'($urandom_range(0, 15));
            @(negedge clk);
            e_if_rdy = 1'b0; e_d_rdy = 1'b0;
            if (cyc >= next_free) begin
                if (if_req_valid && d_req_valid) begin
                    if (starve == LIMIT) e_if_rdy = 1'b1; else e_d_rdy = 1'b1;
                end else if (if_req_valid) e_if_rdy = 1'b1;
                else if (d_req_valid) e_d_rdy = 1'b1;
            end
            if (cyc == rsp_cyc) begin
                if (rsp_if) exp_if = pend_data; else exp_d = pend_data;
            end
            checks++;
            if ({if_req_ready, d_req_ready} !== {e_if_rdy, e_d_rdy})
                $display("[TB] FAIL rnd_ready cycle=%0d got=%b exp=%b", cyc, {if_req_ready, d_req_ready}, {e_if_rdy, e_d_rdy});
            else passed++;
            checks++;
            if (mem_en !== (cyc == mem_cyc)) $display("[TB] FAIL rnd_mem_en cycle=%0d got=%b exp=%b", cyc, mem_en, cyc == mem_cyc);
            else passed++;
            if (cyc == mem_cyc) begin
                checks++;
                if ({mem_we, mem_be, mem_addr, mem_wdata} !== e_mem)
                    $display("[TB] FAIL rnd_mem_fields cycle=%0d got=%h exp=%h", cyc, {mem_we, mem_be, mem_addr, mem_wdata}, e_mem);
                else passed++;
            end
            checks++;
            if ({if_rsp_valid, d_rsp_valid} !== {cyc == rsp_cyc && rsp_if, cyc == rsp_cyc && !rsp_if})
                $display("[TB] FAIL rnd_rsp_valid cycle=%0d got=%b exp=%b", cyc, {if_rsp_valid, d_rsp_valid}, {cyc == rsp_cyc && rsp_if, cyc == rsp_cyc && !rsp_if});
            else passed++;
            checks++;
            if ({if_rsp_data, d_rsp_data} !== {exp_if, exp_d})
                $display("[TB] FAIL rnd_rsp_data cycle=%0d got=%h exp=%h", cyc, {if_rsp_data, d_rsp_data}, {exp_if, exp_d});
            else passed++;
            if (e_if_rdy || e_d_rdy) begin
                next_free = cyc + LAT_A + 3;
                mem_cyc   = cyc + 1;
                rsp_cyc   = cyc + 2 + LAT_A;
                rsp_if    = e_if_rdy;
                if (e_if_rdy) begin
                    e_mem     = {1'b0, 4'hF, if_req_addr, 32'h0};
                    pend_data = mem_val(if_req_addr);
                    starve    = 0;
                end else begin
                    e_mem     = {d_req_we, d_req_be, d_req_addr, d_req_wdata};
                    pend_data = d_req_we ? 32'h0 : mem_val(d_req_addr);
                    if (if_req_valid && starve < LIMIT) starve++;
                end
            end
            step();
        end
        if_req_valid = 1'b0; d_req_valid = 1'b0;
    endtask

    initial begin
        $display("[TB] starting unified_mem_arbiter bench");
        test_reset();
        test_fetch_read();
        test_store();
        test_starvation();
        test_back_to_back();
        test_reset_mid();
        test_latency1();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
